// File: rtl/fsm_moore.sv
// Moore detector for the serial pattern 1-0-1-0 (first bit received first), overlap selectable.
// Latency: out rises one cycle after the edge that samples the final 0; registered state only.
// Backpressure: none; bit_in is consumed on every rising clk edge.
//
// Ports:
//   clk    - single clock, all state updates on its rising edge
//   rst_n  - asynchronous active-low reset, forces S0 / out=0 immediately
//   bit_in - serial data bit, sampled every rising edge
//   out    - detect flag, high only while the machine sits in S4
//
// Parameter:
//   OVERLAP - 1: a detection's trailing "10" may start the next match
//             0: after a detection matching restarts from scratch
module fsm_moore #(
  parameter int OVERLAP = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  output logic out
);

  // Each state names the longest prefix of 1010 that ends the received stream.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // no prefix
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "10"
    S3 = 3'd3,  // "101"
    S4 = 3'd4   // "1010" complete
  } state_t;

  state_t state;
  state_t state_d;

  // The state register is the only storage in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S0;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = S0;
    case (state)
      S0: state_d = bit_in ? S1 : S0;
      // A repeated 1 is still a valid one-bit prefix.
      S1: state_d = bit_in ? S1 : S2;
      // "100" shares no prefix with 1010, so fall all the way back.
      S2: state_d = bit_in ? S3 : S0;
      // "1011" keeps only its last "1" as a usable prefix.
      S3: state_d = bit_in ? S1 : S4;
      S4: begin
        if (bit_in) begin
          // With overlap the trailing "10" of the match plus this 1 is "101".
          state_d = (OVERLAP != 0) ? S3 : S1;
        end else begin
          state_d = S0;
        end
      end
      // Encodings 5..7 are unreachable; recover to idle if ever seen.
      default: state_d = S0;
    endcase
  end

  // Pure function of the registered state: no path from bit_in.
  assign out = (state == S4);

endmodule

// File: tb/tb_fsm_moore.sv
module tb_fsm_moore;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic bit_in;
  logic out_ov;
  logic out_no;

  fsm_moore #(.OVERLAP(1)) u_ov (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_in (bit_in),
    .out    (out_ov)
  );

  fsm_moore #(.OVERLAP(0)) u_no (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_in (bit_in),
    .out    (out_no)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of sampled bits since reset. A match is the last
  // four bits equalling 1,0,1,0; without overlap the four bits must also all
  // lie after the final bit of the previous match.
  bit hist[$];
  int last_det;
  logic exp_ov;
  logic exp_no;

  task automatic model_reset();
    hist.delete();
    last_det = -1;
    exp_ov = 1'b0;
    exp_no = 1'b0;
  endtask

  task automatic model_push(input bit b);
    int n;
    bit hit;
    hist.push_back(b);
    n = hist.size();
    hit = (n >= 4) && hist[n-4] && !hist[n-3] && hist[n-2] && !hist[n-1];
    exp_ov = hit;
    exp_no = hit && ((n - 4) > last_det);
    if (exp_no) last_det = n - 1;
  endtask

  // Present one bit, let one rising edge sample it, settle off the edge.
  task automatic step(input logic b);
    bit_in = b;
    @(posedge clk);
    #1;
    model_push(b);
  endtask

  // Asynchronous reset asserted between edges, held 3 cycles, released on a falling edge.
  task automatic apply_reset(input logic hold_bit);
    bit_in = hold_bit;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_ov", 32'(out_ov), 32'd0);
    chk("rst_async_out_no", 32'(out_no), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_out_ov", 32'(out_ov), 32'd0);
      chk("rst_hold_out_no", 32'(out_no), 32'd0);
      chk("rst_hold_st_ov", 32'(u_ov.state), 32'd0);
      chk("rst_hold_st_no", 32'(u_no.state), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Directed vectors: rst = reset before this bit; s_* are state numbers (S0..S4).
  typedef struct {
    bit   rst;
    logic b;
    logic o_ov;
    logic o_no;
    int   s_ov;
    int   s_no;
  } vec_t;

  vec_t tbl[26];

  initial begin
    rst_n  = 1'b0;
    bit_in = 1'b0;
    model_reset();

    // Long run with both overlap settings.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 3};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4, 4};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    // 101010 from reset.
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 3};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 4, 4};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 1};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 2};
    // Near miss 10010110.
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 3};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 2};

    // Reset state with bit_in held high, then release.
    bit_in = 1'b1;
    #1;
    chk("por_out_ov", 32'(out_ov), 32'd0);
    chk("por_out_no", 32'(out_no), 32'd0);
    apply_reset(1'b1);

    for (int i = 0; i < 26; i++) begin
      if (tbl[i].rst) apply_reset(1'b1);
      step(tbl[i].b);
      chk($sformatf("vec%0d_out_ov", i), 32'(out_ov), 32'(tbl[i].o_ov));
      chk($sformatf("vec%0d_out_no", i), 32'(out_no), 32'(tbl[i].o_no));
      chk($sformatf("vec%0d_st_ov", i),  32'(u_ov.state), 32'(tbl[i].s_ov));
      chk($sformatf("vec%0d_st_no", i),  32'(u_no.state), 32'(tbl[i].s_no));
    end

    // Reset while sitting in S4: the match must not carry over.
    apply_reset(1'b0);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    chk("mid_pre_out_ov", 32'(out_ov), 32'd1);
    chk("mid_pre_out_no", 32'(out_no), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_out_ov", 32'(out_ov), 32'd0);
    chk("mid_async_out_no", 32'(out_no), 32'd0);
    chk("mid_async_st_ov", 32'(u_ov.state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1);
    chk("mid_rel1_out_ov", 32'(out_ov), 32'd0);
    chk("mid_rel1_st_ov", 32'(u_ov.state), 32'd1);
    step(1'b0);
    chk("mid_rel2_out_ov", 32'(out_ov), 32'd0);
    chk("mid_rel2_out_no", 32'(out_no), 32'd0);
    chk("mid_rel2_st_ov", 32'(u_ov.state), 32'd2);
    chk("mid_rel2_st_no", 32'(u_no.state), 32'd2);

    // Random run against the history model, with occasional async resets.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rnd_rst_out_ov", 32'(out_ov), 32'd0);
        chk("rnd_rst_out_no", 32'(out_no), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
      end
      step(1'($urandom_range(0, 1)));
      chk("rnd_out_ov", 32'(out_ov), 32'(exp_ov));
      chk("rnd_out_no", 32'(out_no), 32'(exp_no));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_moore.md
FSM_MOORE -- requirements
Module: fsm_moore

Interface
REQ-001 The block SHALL have one parameter: OVERLAP, default 1, meaning 1 = overlapping detection, 0 = non-overlapping detection.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port bit_in, input, 1 bit, the serial data bit, sampled on every rising clk edge.
REQ-005 The block SHALL have port out, output, 1 bit, the detect flag; it is high while the sequence 1010 has just been completed.

Function
REQ-006 The block SHALL be a Moore machine detecting the serial sequence 1-0-1-0, with the first bit received first.
REQ-007 The block SHALL use exactly five states: S0 (IDLE, no prefix), S1 ("1"), S2 ("10"), S3 ("101") and S4 ("1010" detected).
REQ-008 out SHALL be a function of the current state only: 1 in S4, 0 in every other state; bit_in SHALL have no combinational path to out.
REQ-009 S0 SHALL go to S1 on bit_in=1 and stay in S0 on bit_in=0.
REQ-010 S1 SHALL stay in S1 on bit_in=1 and go to S2 on bit_in=0.
REQ-011 S2 SHALL go to S3 on bit_in=1 and go to S0 on bit_in=0.
REQ-012 S3 SHALL go to S1 on bit_in=1 and go to S4 on bit_in=0.
REQ-013 With OVERLAP=1, S4 SHALL go to S3 on bit_in=1 (reuses the trailing "10") and to S0 on bit_in=0.
REQ-014 With OVERLAP=0, S4 SHALL go to S1 on bit_in=1 and to S0 on bit_in=0.
REQ-015 Latency SHALL be: out rises in the cycle after the rising edge that samples the final 0 of the sequence, and stays high for exactly one clock period unless a new detection immediately follows.
REQ-016 Any unused state encoding SHALL return to S0 on the next rising edge, with out=0.
REQ-017 The state register SHALL be the only sequential element; next-state logic SHALL be combinational and fully specified, with no latches.

Reset
REQ-018 While rst_n=0, state SHALL be S0 and out SHALL be 0 immediately, independent of clk.
REQ-019 Asserting rst_n mid-sequence, including while in S4, SHALL discard the partial match; detection restarts from S0 after release.
REQ-020 The first rising edge after rst_n goes high SHALL be treated as a normal edge that samples bit_in.

Verification
REQ-021 Reset check: hold rst_n=0 with bit_in=1 for 3 clock cycles -> out=0 and state=S0 throughout; drop rst_n between clock edges -> out=0 at once.
REQ-022 Directed run: with OVERLAP=1, release reset and sample bit_in = 1,1,1,0,0,1,0,1,0,1,0,0 on successive edges -> state path S1,S1,S1,S2,S0,S1,S2,S3,S4,S3,S4,S0; out=1 only after the 9th and 11th edges.
REQ-023 Non-overlap: with OVERLAP=0, sample bit_in = 1,0,1,0,1,0 -> out=1 after the 4th edge only; after the 6th edge state=S2 and out=0.
REQ-024 Near miss: sample bit_in = 1,0,0,1,0,1,1,0 -> out stays 0 throughout; final state=S2.
REQ-025 Reset mid-operation: reach S4 (out=1), then assert rst_n=0 asynchronously -> out=0 at once; after release, sample bit_in = 1,0 -> out=0 (no carried-over match).
REQ-026 Random run: 10k random bits compared against a reference shift-register model of the last four bits (honouring OVERLAP) -> out matches on every cycle.
